// File: rtl/g_rr_arb4_if.sv
// rtl/g_rr_arb4_if.sv - request/grant bundle between requesters and the round-robin arbiter
// LOCKN exists only when G_RRARB_LOCK_EN is defined.
interface g_rr_arb4_if #(
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  REQN;
  logic [N-1:0]  GNT;
  logic [IW-1:0] GNTID;
  logic          BUSY;
  logic          TMO;
`ifdef G_RRARB_LOCK_EN
  logic          LOCKN;

  modport master (output REQN, output LOCKN, input GNT, input GNTID, input BUSY, input TMO);
  modport slave  (input REQN, input LOCKN, output GNT, output GNTID, output BUSY, output TMO);
`else
  modport master (output REQN, input GNT, input GNTID, input BUSY, input TMO);
  modport slave  (input REQN, output GNT, output GNTID, output BUSY, output TMO);
`endif
endinterface

// File: rtl/g_rr_arb4.sv
// rtl/g_rr_arb4.sv - round-robin arbiter with bounded tenure and one-cycle break-before-make gap
// Optional tenure lock (LOCKN) enabled by defining G_RRARB_LOCK_EN.
module g_rr_arb4 #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 16
) (
  input  logic        CK,
  input  logic        CD,
  g_rr_arb4_if.slave  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(HOLD_MAX + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gntid;
  logic [HW-1:0] hcnt;
  logic [N-1:0]  gnt;
  logic          busy;
  logic          tmo;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          lock;
  logic          at_max;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] p);
    if (p == IW'(N - 1)) return '0;
    return p + 1'b1;
  endfunction

  // First active-low request found walking from ptr upward with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = ptr;
    for (int k = 0; k < N; k++) begin
      if (!win_found && !bus.REQN[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = next_idx(cand);
    end
  end

`ifdef G_RRARB_LOCK_EN
  assign lock = !bus.LOCKN;
`else
  assign lock = 1'b0;
`endif

  assign at_max = (hcnt == HW'(HOLD_MAX));

  always_ff @(posedge CK) begin
    if (CD) begin
      state <= ST_IDLE;
      ptr   <= '0;
      gntid <= '0;
      hcnt  <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      tmo <= 1'b0;
      case (state)
        ST_IDLE, ST_GAP: begin
          if (win_found) begin
            gnt   <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            gntid <= win_idx;
            busy  <= 1'b1;
            hcnt  <= HW'(1);
            state <= ST_OWN;
          end else begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_OWN: begin
          // Release has priority over expiry, so a simultaneous pair never pulses TMO.
          if (bus.REQN[gntid]) begin
            gnt   <= '0;
            busy  <= 1'b0;
            hcnt  <= '0;
            ptr   <= next_idx(gntid);
            state <= ST_GAP;
          end else if (at_max && !lock) begin
            gnt   <= '0;
            busy  <= 1'b0;
            hcnt  <= '0;
            tmo   <= 1'b1;
            ptr   <= next_idx(gntid);
            state <= ST_GAP;
          end else if (!at_max) begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          hcnt  <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.GNT   = gnt;
  assign bus.GNTID = gntid;
  assign bus.BUSY  = busy;
  assign bus.TMO   = tmo;

endmodule

// File: tb/tb_g_rr_arb4.sv
// tb/tb_g_rr_arb4.sv - directed self-checking bench for g_rr_arb4
// Lock scenario runs only when G_RRARB_LOCK_EN is defined.
module tb_g_rr_arb4;
  logic CK = 1'b0;
  logic CD = 1'b1;
  int   tests = 0;
  int   fails = 0;

  g_rr_arb4_if #(.N(4)) bus ();

  g_rr_arb4 #(.N(4), .HOLD_MAX(16)) dut (
    .CK  (CK),
    .CD  (CD),
    .bus (bus)
  );

  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    CD = 1'b1;
    bus.REQN = 4'b1111;
    tick();
    tick();
    tests++; if (bus.GNT !== 4'b0000) begin fails++; $display("FAIL reset_gnt got %b want 0000", bus.GNT); end
    tests++; if (bus.GNTID !== 2'd0) begin fails++; $display("FAIL reset_gntid got %0d want 0", bus.GNTID); end
    tests++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.BUSY); end
    tests++; if (bus.TMO !== 1'b0) begin fails++; $display("FAIL reset_tmo got %b want 0", bus.TMO); end
    CD = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++; if (bus.GNT !== 4'b0000 || bus.BUSY !== 1'b0) begin
        fails++; $display("FAIL idle_after_reset cyc%0d got gnt=%b busy=%b want 0000/0", c, bus.GNT, bus.BUSY);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    bus.REQN = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      exp = 4'b0001 << i;
      for (int c = 0; c < 3; c++) begin
        tick();
        tests++; if (bus.GNT !== exp || bus.GNTID !== 2'(i) || bus.BUSY !== 1'b1) begin
          fails++; $display("FAIL rot_grant r%0d c%0d got gnt=%b id=%0d busy=%b want %b/%0d/1", i, c, bus.GNT, bus.GNTID, bus.BUSY, exp, i);
        end
      end
      bus.REQN[i] = 1'b1;
      tick();
      tests++; if (bus.GNT !== 4'b0000 || bus.BUSY !== 1'b0 || bus.TMO !== 1'b0) begin
        fails++; $display("FAIL rot_gap r%0d got gnt=%b busy=%b tmo=%b want 0000/0/0", i, bus.GNT, bus.BUSY, bus.TMO);
      end
      bus.REQN[i] = 1'b0;
    end
    tick();
    tests++; if (bus.GNT !== 4'b0001) begin fails++; $display("FAIL rot_wrap got %b want 0001", bus.GNT); end
    bus.REQN = 4'b1111;
    tick();
    tick();
  endtask

  task automatic test_expiry();
    bus.REQN = 4'b1110;
    tick();
    for (int c = 0; c < 16; c++) begin
      tests++; if (bus.GNT !== 4'b0001 || bus.TMO !== 1'b0) begin
        fails++; $display("FAIL exp_hold c%0d got gnt=%b tmo=%b want 0001/0", c, bus.GNT, bus.TMO);
      end
      tick();
    end
    tests++; if (bus.GNT !== 4'b0000 || bus.TMO !== 1'b1) begin
      fails++; $display("FAIL exp_tmo got gnt=%b tmo=%b want 0000/1", bus.GNT, bus.TMO);
    end
    tick();
    tests++; if (bus.GNT !== 4'b0001 || bus.TMO !== 1'b0) begin
      fails++; $display("FAIL exp_regrant got gnt=%b tmo=%b want 0001/0", bus.GNT, bus.TMO);
    end
    bus.REQN = 4'b1111;
    tick();
    tests++; if (bus.TMO !== 1'b0) begin fails++; $display("FAIL exp_release_tmo got %b want 0", bus.TMO); end
    tick();
  endtask

  task automatic test_preempt();
    bus.REQN = 4'b1110;
    tick();
    for (int c = 0; c < 16; c++) begin
      if (c == 4) bus.REQN = 4'b1010;
      tests++; if (bus.GNT !== 4'b0001) begin
        fails++; $display("FAIL pre_hold c%0d got %b want 0001", c, bus.GNT);
      end
      tick();
    end
    tests++; if (bus.GNT !== 4'b0000 || bus.TMO !== 1'b1) begin
      fails++; $display("FAIL pre_gap got gnt=%b tmo=%b want 0000/1", bus.GNT, bus.TMO);
    end
    tick();
    tests++; if (bus.GNT !== 4'b0100 || bus.GNTID !== 2'd2) begin
      fails++; $display("FAIL pre_switch got gnt=%b id=%0d want 0100/2", bus.GNT, bus.GNTID);
    end
    bus.REQN = 4'b0110;
    tick();
    tests++; if (bus.GNT !== 4'b0000) begin fails++; $display("FAIL pre_gap2 got %b want 0000", bus.GNT); end
    tick();
    tests++; if (bus.GNT !== 4'b1000 || bus.GNTID !== 2'd3) begin
      fails++; $display("FAIL pre_ptr3 got gnt=%b id=%0d want 1000/3", bus.GNT, bus.GNTID);
    end
    bus.REQN = 4'b1100;
    tick();
    tick();
    tests++; if (bus.GNT !== 4'b0001 || bus.GNTID !== 2'd0) begin
      fails++; $display("FAIL pre_ptr_wrap got gnt=%b id=%0d want 0001/0", bus.GNT, bus.GNTID);
    end
    bus.REQN = 4'b1111;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.REQN = 4'b1011;
    tick();
    tests++; if (bus.GNT !== 4'b0100) begin fails++; $display("FAIL mid_grant got %b want 0100", bus.GNT); end
    for (int c = 0; c < 4; c++) tick();
    CD = 1'b1;
    bus.REQN = 4'b0000;
    tick();
    tests++; if (bus.GNT !== 4'b0000 || bus.BUSY !== 1'b0 || bus.GNTID !== 2'd0 || bus.TMO !== 1'b0) begin
      fails++; $display("FAIL mid_reset got gnt=%b busy=%b id=%0d tmo=%b want 0000/0/0/0", bus.GNT, bus.BUSY, bus.GNTID, bus.TMO);
    end
    CD = 1'b0;
    tick();
    tests++; if (bus.GNT !== 4'b0001) begin fails++; $display("FAIL mid_ptr0 got %b want 0001", bus.GNT); end
    bus.REQN = 4'b1111;
    tick();
    tick();
  endtask

`ifdef G_RRARB_LOCK_EN
  task automatic test_lock();
    bus.REQN  = 4'b1110;
    bus.LOCKN = 1'b0;
    tick();
    for (int c = 0; c < 40; c++) begin
      tests++; if (bus.GNT !== 4'b0001 || bus.TMO !== 1'b0) begin
        fails++; $display("FAIL lock_hold c%0d got gnt=%b tmo=%b want 0001/0", c, bus.GNT, bus.TMO);
      end
      tick();
    end
    bus.REQN = 4'b1111;
    tick();
    tests++; if (bus.GNT !== 4'b0000 || bus.TMO !== 1'b0) begin
      fails++; $display("FAIL lock_release got gnt=%b tmo=%b want 0000/0", bus.GNT, bus.TMO);
    end
    bus.LOCKN = 1'b1;
    tick();
  endtask
`endif

  initial begin
    bus.REQN = 4'b1111;
`ifdef G_RRARB_LOCK_EN
    bus.LOCKN = 1'b1;
`endif
    test_reset();
    test_rotation();
    test_expiry();
    test_preempt();
    test_reset_mid();
`ifdef G_RRARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
